// File: rtl/fetch_branch_predictor_pkg.sv
// ----------------------------------------------------------------------------
// fetch_branch_predictor_pkg
//
// Shared LC-3b types used by the fetch-side branch target buffer:
//   lc3b_word       16-bit machine word / address
//   lc3b_btb_ctr    2-bit saturating direction counter
//   lc3b_btb_entry  one BTB entry {valid, tag, target, ctr}
//
// The tag field is sized for the largest tag any table geometry can need
// (15 bits, i.e. pc[15:1]). A table with INDEX_BITS index bits stores its
// (15-INDEX_BITS)-bit tag zero-extended into this field, so every
// geometry shares one entry layout.
// ----------------------------------------------------------------------------
package fetch_branch_predictor_pkg;

   typedef logic [15:0] lc3b_word;
   typedef logic [1:0]  lc3b_btb_ctr;

   localparam int BTB_TAG_MAX_W = 15;

   // Counter encodings: 0/1 predict not taken, 2/3 predict taken.
   localparam lc3b_btb_ctr BTB_CTR_RESET = 2'b01;
   localparam lc3b_btb_ctr BTB_CTR_ALLOC = 2'b10;

   typedef struct packed {
      logic                     valid;
      logic [BTB_TAG_MAX_W-1:0] tag;
      lc3b_word                 target;
      lc3b_btb_ctr              ctr;
   } lc3b_btb_entry;

   localparam lc3b_btb_entry BTB_ENTRY_RESET = '{
      valid  : 1'b0,
      tag    : '0,
      target : '0,
      ctr    : BTB_CTR_RESET
   };

   // Sequential fall-through address; LC-3b instructions are 2 bytes and
   // the add deliberately wraps at the top of the address space.
   function automatic lc3b_word pc_plus2(input lc3b_word pc);
      return pc + 16'd2;
   endfunction

endpackage

// File: rtl/fetch_branch_predictor_sat_counter2.sv
// ----------------------------------------------------------------------------
// sat_counter2
//
// Combinational next-state function of a 2-bit saturating direction counter.
// Counts up on a taken outcome, down otherwise, and sticks at 0 and 3.
//
// Ports:
//   ctr       in   current counter value
//   taken     in   resolved direction of the branch
//   next_ctr  out  counter value after training with 'taken'
// ----------------------------------------------------------------------------
module sat_counter2
   import fetch_branch_predictor_pkg::*;
(
   input  lc3b_btb_ctr ctr,
   input  logic        taken,
   output lc3b_btb_ctr next_ctr
);

   // Move one step toward the observed direction unless already at the
   // end of the range in that direction.
   always_comb begin
      next_ctr = ctr;
      if (taken) begin
         if (ctr != 2'b11) begin
            next_ctr = ctr + 2'd1;
         end
      end else begin
         if (ctr != 2'b00) begin
            next_ctr = ctr - 2'd1;
         end
      end
   end

endmodule

// File: rtl/fetch_branch_predictor.sv
// ----------------------------------------------------------------------------
// fetch_branch_predictor
//
// Direct-mapped branch target buffer with 2-bit direction counters for the
// LC-3b fetch stage. The lookup is purely combinational on fetch_pc; the
// table is trained by the instruction retiring in write-back.
//
// Parameters:
//   INDEX_BITS          log2 of the entry count; index = pc[INDEX_BITS:1],
//                       tag = pc[15:INDEX_BITS+1]
//
// Ports:
//   clk                 in   pipeline clock, table written on rising edge
//   reset               in   async active-high, clears the whole table
//   fetch_pc            in   PC of the instruction being fetched
//   predicted_pc        out  predicted next fetch address
//   branch_prediction   out  1 = BTB hit with counter in a taken state
//   wb_valid            in   a retiring instruction is present
//   wb_pc               in   address of the retiring instruction
//   wb_is_control       in   retiring opcode is br/jmp/jsr/trap
//   wb_taken            in   resolved direction
//   wb_target           in   resolved target address
//   wb_predicted_taken  in   prediction that travelled with the instruction
// ----------------------------------------------------------------------------
module fetch_branch_predictor
   import fetch_branch_predictor_pkg::*;
#(
   parameter int INDEX_BITS = 4
) (
   input  logic     clk,
   input  logic     reset,
   input  lc3b_word fetch_pc,
   output lc3b_word predicted_pc,
   output logic     branch_prediction,
   input  logic     wb_valid,
   input  lc3b_word wb_pc,
   input  logic     wb_is_control,
   input  logic     wb_taken,
   input  lc3b_word wb_target,
   input  logic     wb_predicted_taken
);

   localparam int ENTRIES = 1 << INDEX_BITS;

   lc3b_btb_entry btb_q [ENTRIES];

   logic [INDEX_BITS-1:0]    fetch_idx;
   logic [BTB_TAG_MAX_W-1:0] fetch_tag;
   lc3b_btb_entry            fetch_entry;
   logic                     fetch_hit;

   logic [INDEX_BITS-1:0]    wb_idx;
   logic [BTB_TAG_MAX_W-1:0] wb_tag;
   lc3b_btb_entry            wb_entry;
   logic                     wb_hit;
   lc3b_btb_ctr              wb_next_ctr;

   logic                     upd_en;
   lc3b_btb_entry            upd_entry;

   // Bit 0 of a retiring PC is always zero for aligned instructions and
   // plays no part in indexing or tagging.
   logic                     unused_wb_pc_lsb;
   assign unused_wb_pc_lsb = wb_pc[0];

   // Split both PCs into index and zero-extended tag so stored tags and
   // lookup tags always compare across the full shared tag field.
   assign fetch_idx = fetch_pc[INDEX_BITS:1];
   assign fetch_tag = {{INDEX_BITS{1'b0}}, fetch_pc[15:INDEX_BITS+1]};
   assign wb_idx    = wb_pc[INDEX_BITS:1];
   assign wb_tag    = {{INDEX_BITS{1'b0}}, wb_pc[15:INDEX_BITS+1]};

   assign fetch_entry = btb_q[fetch_idx];
   assign wb_entry    = btb_q[wb_idx];
   assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
   assign wb_hit      = wb_entry.valid && (wb_entry.tag == wb_tag);

   // Zero-latency prediction straight off the table contents. Because the
   // table clears asynchronously, the outputs fall back to the sequential
   // path as soon as reset rises.
   always_comb begin
      branch_prediction = fetch_hit && fetch_entry.ctr[1];
      predicted_pc      = pc_plus2(fetch_pc);
      if (branch_prediction) begin
         predicted_pc = fetch_entry.target;
      end
   end

   sat_counter2 u_sat_counter2 (
      .ctr      (wb_entry.ctr),
      .taken    (wb_taken),
      .next_ctr (wb_next_ctr)
   );

   // Build the replacement entry for the retiring instruction. Hits train
   // the counter (and refresh the target on taken), taken misses allocate
   // a weakly-taken entry over whatever was there, and a non-branch that
   // was predicted taken kills the aliased entry that caused the bogus
   // prediction so the same flush does not repeat.
   always_comb begin
      upd_en    = 1'b0;
      upd_entry = wb_entry;
      if (wb_valid) begin
         if (wb_is_control) begin
            if (wb_hit) begin
               upd_en        = 1'b1;
               upd_entry.ctr = wb_next_ctr;
               if (wb_taken) begin
                  upd_entry.target = wb_target;
               end
            end else if (wb_taken) begin
               upd_en           = 1'b1;
               upd_entry.valid  = 1'b1;
               upd_entry.tag    = wb_tag;
               upd_entry.target = wb_target;
               upd_entry.ctr    = BTB_CTR_ALLOC;
            end
         end else if (wb_predicted_taken && wb_hit) begin
            upd_en          = 1'b1;
            upd_entry.valid = 1'b0;
         end
      end
   end

   // Table storage. Reset wipes every entry at once and overrides any
   // update sampled while it is asserted. There is no write-to-read
   // bypass: a lookup in the same cycle as an update sees the old entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i] <= BTB_ENTRY_RESET;
         end
      end else if (upd_en) begin
         btb_q[wb_idx] <= upd_entry;
      end
   end

endmodule

// File: tb/tb_fetch_branch_predictor.sv
// ----------------------------------------------------------------------------
// tb_fetch_branch_predictor
//
// Table-driven bench for the fetch BTB. Each vector row is one cycle: the
// lookup and the write-back update are driven together, and the expected
// lookup reflects the table as it stood before that row's update. Expected
// outputs go into a scoreboard queue when a row is driven and are popped and
// compared shortly after, before the next rising edge. A hand-written
// sequence follows for asynchronous reset behaviour.
// ----------------------------------------------------------------------------
module tb_fetch_branch_predictor;

   typedef struct {
      string       name;
      logic [15:0] fetch_pc;
      logic        wb_valid;
      logic [15:0] wb_pc;
      logic        wb_is_control;
      logic        wb_taken;
      logic [15:0] wb_target;
      logic        wb_pred_taken;
      logic [15:0] exp_pc;
      logic        exp_pred;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] exp_pc;
      logic        exp_pred;
   } expect_t;

   logic        clk;
   logic        reset;
   logic [15:0] fetch_pc;
   logic [15:0] predicted_pc;
   logic        branch_prediction;
   logic        wb_valid;
   logic [15:0] wb_pc;
   logic        wb_is_control;
   logic        wb_taken;
   logic [15:0] wb_target;
   logic        wb_predicted_taken;

   int          compared;
   int          mismatched;
   vec_t        vecs[$];
   expect_t     sb_q[$];

   fetch_branch_predictor #(.INDEX_BITS(4)) dut (
      .clk                (clk),
      .reset              (reset),
      .fetch_pc           (fetch_pc),
      .predicted_pc       (predicted_pc),
      .branch_prediction  (branch_prediction),
      .wb_valid           (wb_valid),
      .wb_pc              (wb_pc),
      .wb_is_control      (wb_is_control),
      .wb_taken           (wb_taken),
      .wb_target          (wb_target),
      .wb_predicted_taken (wb_predicted_taken)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mk(input string name, input logic [15:0] f_pc,
                               input logic v, input logic [15:0] w_pc,
                               input logic ctl, input logic tk,
                               input logic [15:0] tgt, input logic pt,
                               input logic [15:0] e_pc, input logic e_pred);
      vec_t r;
      r.name          = name;
      r.fetch_pc      = f_pc;
      r.wb_valid      = v;
      r.wb_pc         = w_pc;
      r.wb_is_control = ctl;
      r.wb_taken      = tk;
      r.wb_target     = tgt;
      r.wb_pred_taken = pt;
      r.exp_pc        = e_pc;
      r.exp_pred      = e_pred;
      return r;
   endfunction

   // Drive one cycle of stimulus on the falling edge and record what the
   // lookup must show during that cycle.
   task automatic applyStimulus(input vec_t v);
      expect_t e;
      @(negedge clk);
      fetch_pc           = v.fetch_pc;
      wb_valid           = v.wb_valid;
      wb_pc              = v.wb_pc;
      wb_is_control      = v.wb_is_control;
      wb_taken           = v.wb_taken;
      wb_target          = v.wb_target;
      wb_predicted_taken = v.wb_pred_taken;
      e.name     = v.name;
      e.exp_pc   = v.exp_pc;
      e.exp_pred = v.exp_pred;
      sb_q.push_back(e);
   endtask

   // Pop the oldest expectation and compare it with the live outputs.
   task automatic checkOutput();
      expect_t e;
      compared++;
      if (sb_q.size() == 0) begin
         mismatched++;
         $display("[TB] FAIL scoreboard: no expectation queued, got pc=%h pred=%b",
                  predicted_pc, branch_prediction);
      end else begin
         e = sb_q.pop_front();
         if (predicted_pc !== e.exp_pc || branch_prediction !== e.exp_pred) begin
            mismatched++;
            $display("[TB] FAIL %s: predicted_pc=%h branch_prediction=%b, expected %h/%b",
                     e.name, predicted_pc, branch_prediction, e.exp_pc, e.exp_pred);
         end
      end
   endtask

   task automatic pushExpect(input string name, input logic [15:0] e_pc, input logic e_pred);
      expect_t e;
      e.name     = name;
      e.exp_pc   = e_pc;
      e.exp_pred = e_pred;
      sb_q.push_back(e);
   endtask

   initial begin
      compared           = 0;
      mismatched         = 0;
      reset              = 1'b1;
      fetch_pc           = 16'h0000;
      wb_valid           = 1'b0;
      wb_pc              = 16'h0000;
      wb_is_control      = 1'b0;
      wb_taken           = 1'b0;
      wb_target          = 16'h0000;
      wb_predicted_taken = 1'b0;

      // Rows: name, fetch, wb_valid, wb_pc, ctl, taken, target, pred_taken, exp_pc, exp_pred
      vecs.push_back(mk("cold",          16'h3000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3002, 0));
      vecs.push_back(mk("cold_wrap",     16'hFFFE, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0));
      vecs.push_back(mk("same_cycle",    16'h3000, 1, 16'h3000, 1, 1, 16'h3040, 0, 16'h3002, 0));
      vecs.push_back(mk("alloc",         16'h3000, 1, 16'h3000, 1, 0, 16'h0000, 0, 16'h3040, 1));
      vecs.push_back(mk("hyst_first",    16'h3000, 1, 16'h3000, 1, 0, 16'h0000, 0, 16'h3002, 0));
      vecs.push_back(mk("hyst_second",   16'h3000, 1, 16'h3000, 1, 1, 16'h3040, 0, 16'h3002, 0));
      vecs.push_back(mk("valid_kept",    16'h3000, 1, 16'h3000, 1, 1, 16'h3040, 0, 16'h3002, 0));
      vecs.push_back(mk("ctr_two",       16'h3000, 1, 16'h3000, 1, 1, 16'h3040, 0, 16'h3040, 1));
      vecs.push_back(mk("ctr_three",     16'h3000, 1, 16'h3000, 1, 1, 16'h3040, 0, 16'h3040, 1));
      vecs.push_back(mk("ctr_saturated", 16'h3000, 1, 16'h3000, 1, 0, 16'h0000, 0, 16'h3040, 1));
      vecs.push_back(mk("sat_dec_once",  16'h3000, 1, 16'h3000, 1, 0, 16'h0000, 0, 16'h3040, 1));
      vecs.push_back(mk("sat_dec_twice", 16'h3000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3002, 0));
      vecs.push_back(mk("alias_miss",    16'h3020, 1, 16'h3000, 1, 1, 16'h3050, 0, 16'h3022, 0));
      vecs.push_back(mk("target_update", 16'h3000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3050, 1));
      vecs.push_back(mk("noctl_no_pred", 16'h3000, 1, 16'h3000, 0, 0, 16'h0000, 0, 16'h3050, 1));
      vecs.push_back(mk("noctl_pred",    16'h3000, 1, 16'h3000, 0, 0, 16'h0000, 1, 16'h3050, 1));
      vecs.push_back(mk("invalidated",   16'h3000, 1, 16'h3000, 1, 0, 16'h0000, 0, 16'h3002, 0));
      vecs.push_back(mk("nt_miss_keep",  16'h3000, 1, 16'h3010, 1, 1, 16'h3004, 0, 16'h3002, 0));
      vecs.push_back(mk("other_index",   16'h3010, 0, 16'h3000, 1, 1, 16'h3060, 0, 16'h3004, 1));
      vecs.push_back(mk("wb_valid_low",  16'h3000, 1, 16'h3000, 1, 1, 16'h3040, 0, 16'h3002, 0));
      vecs.push_back(mk("realloc",       16'h3000, 1, 16'h3020, 1, 1, 16'h3080, 0, 16'h3040, 1));
      vecs.push_back(mk("evicted",       16'h3000, 1, 16'h3000, 0, 0, 16'h0000, 1, 16'h3002, 0));
      vecs.push_back(mk("alias_alloc",   16'h3020, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3080, 1));
      vecs.push_back(mk("tag_guard",     16'h3020, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3080, 1));
      vecs.push_back(mk("empty_top",     16'hFFFE, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 0));

      $display("[TB] starting fetch_branch_predictor bench");

      // Lookup while reset is still held.
      applyStimulus(mk("in_reset", 16'h3000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3002, 0));
      #2 checkOutput();
      @(negedge clk);
      reset = 1'b0;

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         #2 checkOutput();
      end

      // Asynchronous reset: 0x3020 is live, reset rises mid-cycle and the
      // outputs must drop before any clock edge.
      applyStimulus(mk("pre_async", 16'h3020, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3080, 1));
      #1 checkOutput();
      #1 reset = 1'b1;
      pushExpect("async_drop", 16'h3022, 1'b0);
      #1 checkOutput();

      // An update presented while reset is high must be discarded.
      applyStimulus(mk("reset_update", 16'h3000, 1, 16'h3000, 1, 1, 16'h3040, 0, 16'h3002, 0));
      #2 checkOutput();
      @(posedge clk);
      #1;
      wb_valid = 1'b0;
      reset    = 1'b0;

      applyStimulus(mk("post_reset_a", 16'h3000, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3002, 0));
      #2 checkOutput();
      applyStimulus(mk("post_reset_b", 16'h3010, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3012, 0));
      #2 checkOutput();
      applyStimulus(mk("post_reset_c", 16'h3020, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h3022, 0));
      #2 checkOutput();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
